// File: rtl/tv_pkg.sv
// Shared types and defaults for the test-vector capture engine.
package tv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_IN_DEF   = 3;
    localparam int DEPTH_DEF  = 112;
    localparam int SETTLE_DEF = 1;

    // A stored vector is the input pattern followed by the sampled response bit.
    function automatic int vec_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/tv_mem.sv
// Capture memory: one write port, registered read port. The array itself has
// no reset so captured vectors survive an aborted run.
module tv_mem #(
    parameter int W     = 4,
    parameter int DEPTH = 112,
    parameter int AW    = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;

    // Store one vector per SAMPLE cycle.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read every cycle; a same-edge write is not forwarded, so old data returns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tv_recorder.sv
// Exhaustive stimulus generator and response recorder for an N_IN-input
// combinational DUT. Each vector is held SETTLE cycles, then sampled.
module tv_recorder
    import tv_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = 7,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [AW:0]            count,
    input  logic [AW-1:0]          rd_addr,
    output logic [vec_w(N_IN)-1:0] rd_data
);

    localparam int W  = vec_w(N_IN);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          r_state;
    logic [N_IN-1:0] r_pattern;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [SW-1:0]   r_settle;

    logic            w_settled;
    logic            w_last;
    logic            w_wr_en;
    logic [W-1:0]    w_wr_data;

    assign w_settled = (r_settle == SW'(SETTLE - 1));
    assign w_last    = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_wr_en   = (r_state == ST_SAMPLE);
    assign w_wr_data = {r_pattern, dut_out};

    // Run sequencing: start from IDLE/DONE, settle, sample, advance pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_settle  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_DRIVE;
                        r_pattern <= '0;
                        r_wr_ptr  <= '0;
                        r_count   <= '0;
                        r_settle  <= '0;
                    end
                end
                ST_DRIVE: begin
                    r_settle <= r_settle + 1'b1;
                    if (w_settled) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_count <= {1'b0, r_wr_ptr} + 1'b1;
                    if (w_last) begin
                        // Pattern is left as-is so dut_in keeps the final vector.
                        r_state <= ST_DONE;
                    end else begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_pattern <= r_pattern + 1'b1;
                        r_settle  <= '0;
                        r_state   <= ST_DRIVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    tv_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    // Status follows the state register directly, so reset clears it at once.
    assign busy   = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign done   = (r_state == ST_DONE);
    assign count  = r_count;
    assign dut_in = r_pattern;

endmodule

// File: tb/tb_tv_recorder.sv
// Scoreboarded bench: random truth-table DUTs, reads checked by a monitor.
module tb_tv_recorder;

    localparam logic [7:0] NAND3 = 8'b0111_1111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [7:0] count_a, count_b;
    logic [6:0] rd_addr = '0;
    logic [3:0] rd_a, rd_b;
    logic [7:0] tt_a = '0, tt_b = '0;
    logic       p1_b = 1'b0, p2_b = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit         sel;
        int         addr;
        logic [3:0] exp;
    } rd_t;
    rd_t        rq[$];
    logic       rd_req = 1'b0;
    logic       req_d = 1'b0;
    logic [3:0] exp_a [112];
    logic [3:0] exp_b [112];

    always #5 clk = ~clk;

    assign dut_out_a = tt_a[dut_in_a];
    always @(posedge clk) begin
        p1_b <= tt_b[dut_in_b];
        p2_b <= p1_b;
    end
    assign dut_out_b = p2_b;

    tv_recorder dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .count(count_a), .rd_addr(rd_addr), .rd_data(rd_a)
    );

    tv_recorder #(.SETTLE(3)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .count(count_b), .rd_addr(rd_addr), .rd_data(rd_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected word for vector i of a run against truth table tt.
    function automatic logic [3:0] ent(input int i, input logic [7:0] tt);
        logic [2:0] p;
        p = 3'(i % 8);
        return {p, tt[p]};
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic [3:0] exp_of(input bit sel, input int i);
        return sel ? exp_b[i] : exp_a[i];
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic push_rd(input bit sel, input int addr, input logic [3:0] exp);
        rd_t e;
        e.sel = sel; e.addr = addr; e.exp = exp;
        rq.push_back(e);
        rd_addr = 7'(addr);
        rd_req = 1'b1;
    endtask

    task automatic rd(input bit sel, input int addr, input logic [3:0] exp);
        push_rd(sel, addr, exp);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic sweep(input bit sel);
        for (int i = 0; i < 112; i++) rd(sel, i, exp_of(sel, i));
    endtask

    task automatic check_status(input string tag, input bit sel, input logic b, input logic d, input int c);
        chk({tag, "_busy"},  sel ? busy_b  : busy_a, b);
        chk({tag, "_done"},  sel ? done_b  : done_a, d);
        chk({tag, "_count"}, sel ? count_b : count_a, c);
    endtask

    // One complete capture run; optional ignored re-starts and mid-run reads of addr 111.
    task automatic run(input bit sel, input logic [7:0] tt, input bit repulse,
                       input bit rd111, input logic [3:0] old111, input int exp_cyc);
        int cyc;
        if (sel) tt_b = tt; else tt_a = tt;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        check_status("start", sel, 1'b1, 1'b0, 0);
        chk("start_dut_in", sel ? dut_in_b : dut_in_a, 0);
        cyc = 0;
        while (busy_of(sel) && cyc < 2000) begin
            set_start(sel, repulse && (cyc == 18 || cyc == 98));
            if (rd111 && (cyc == 50 || cyc == 200)) push_rd(sel, 111, old111);
            else rd_req = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        set_start(sel, 1'b0);
        rd_req = 1'b0;
        chk("run_cycles", cyc, exp_cyc);
        check_status("end", sel, 1'b0, 1'b1, 112);
        chk("end_dut_in", sel ? dut_in_b : dut_in_a, 7);
        for (int i = 0; i < 112; i++) begin
            if (sel) exp_b[i] = ent(i, tt); else exp_a[i] = ent(i, tt);
        end
    endtask

    // Read monitor: data appears one cycle after the address was presented.
    always @(posedge clk) req_d <= rd_req;
    always @(negedge clk) begin
        if (req_d) begin
            if (rq.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                rd_t e;
                e = rq.pop_front();
                chk($sformatf("rd%0d[%0d]", e.sel, e.addr), e.sel ? rd_b : rd_a, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tt;
        int a;
        #1 rst_n = 1'b0;
        #1;
        check_status("rst", 0, 1'b0, 1'b0, 0);
        chk("rst_dut_in", dut_in_a, 0);
        chk("rst_rd_data", rd_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_status("idle", 0, 1'b0, 1'b0, 0);

        // NAND3 baseline run plus directed read-backs.
        run(0, NAND3, 1'b0, 1'b0, 4'h0, 224);
        rd(0, 0, 4'b0001); rd(0, 3, 4'b0111); rd(0, 7, 4'b1110);
        rd(0, 8, 4'b0001); rd(0, 111, 4'b1110);
        sweep(0);

        // Restart from DONE with a random DUT, ignored re-starts, and old data at 111.
        tt = 8'($urandom);
        run(0, tt, 1'b1, 1'b1, 4'b1110, 224);
        sweep(0);
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 111);
            rd(0, a, exp_a[a]);
        end

        // Abort a NAND3 run with reset 48 edges in; 24 vectors land before it.
        tt_a = NAND3;
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        repeat (48) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check_status("abort", 0, 1'b0, 1'b0, 0);
        chk("abort_dut_in", dut_in_a, 0);
        chk("abort_rd_data", rd_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 24; i++) exp_a[i] = ent(i, NAND3);
        sweep(0);

        // Stuck-at-0 DUT after the abort.
        run(0, 8'h00, 1'b0, 1'b0, 4'h0, 224);
        rd(0, 5, 4'b1010);
        sweep(0);

        // Slow registered DUT with a longer settle time.
        tt = 8'($urandom);
        run(1, tt, 1'b0, 1'b0, 4'h0, 448);
        sweep(1);

        repeat (3) @(posedge clk); #1;
        chk("rd_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
